// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter.
package wb_pkg;

   localparam int WB_XLEN   = 32;
   localparam int WB_VLANES = 4;

   localparam int ERR_OVF = 0;
   localparam int ERR_UNF = 1;
   localparam int ERR_COL = 2;

   typedef struct packed {
      logic [4:0]         addr;
      logic [WB_XLEN-1:0] data;
   } wb_reg_entry_t;

   typedef struct packed {
      logic [4:0]                   addr;
      logic [WB_VLANES*WB_XLEN-1:0] data;
   } wb_vec_entry_t;

endpackage

// File: rtl/wb_buffer.sv
// Small synchronous FIFO holding displaced vector-pipe results.
// The head is presented combinationally. A pop on an empty FIFO is ignored.
// A push on a full FIFO is accepted only when a pop frees a slot in the same cycle.
module wb_buffer #(
   parameter int  WIDTH = 37,
   parameter int  DEPTH = 2,
   localparam int CW    = $clog2(DEPTH + 1),
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic [CW-1:0]    count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q,  count_d;
   logic             do_push, do_pop;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign dout    = mem_q[rd_ptr_q];
   assign count   = count_q;
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Next pointers and occupancy from the accepted push/pop.
   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers; reset empties the FIFO.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage write; contents are meaningless until covered by the pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/writeback_arbiter.sv
// Shared writeback stage: selects between drained buffer entries, direct
// vector-pipe results and scalar-pipe results for each register file port,
// buffers displaced vector-pipe results, and keeps sticky error flags.
module writeback_arbiter
   import wb_pkg::*;
#(
   parameter int  XLEN      = WB_XLEN,
   parameter int  VLANES    = WB_VLANES,
   parameter int  BUF_DEPTH = 2,
   localparam int VW        = VLANES * XLEN,
   localparam int CW        = $clog2(BUF_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_reg_wr_en,
   input  logic              s_vec_wr_en,
   input  logic [4:0]        s_wr_reg,
   input  logic [XLEN-1:0]   s_reg_data,
   input  logic [VW-1:0]     s_vec_data,
   input  logic              v_reg_wr_en,
   input  logic              v_vec_wr_en,
   input  logic [4:0]        v_wr_reg,
   input  logic [XLEN-1:0]   v_reg_data,
   input  logic [VW-1:0]     v_vec_data,
   input  logic              register_wb_sel,
   input  logic              vector_wb_sel,
   input  logic              buffer_register,
   input  logic              buffer_vector,
   input  logic              buffer_register_sel,
   input  logic              buffer_vector_sel,
   output logic              rf_wr_en,
   output logic [4:0]        rf_wr_addr,
   output logic [XLEN-1:0]   rf_wr_data,
   output logic              vf_wr_en,
   output logic [4:0]        vf_wr_addr,
   output logic [VW-1:0]     vf_wr_data,
   output logic [CW-1:0]     reg_buf_count,
   output logic [CW-1:0]     vec_buf_count,
   output logic [2:0]        err
);

   logic [XLEN+4:0] reg_head, vec_head_unused;
   logic [VW+4:0]   vec_head;
   logic            reg_full, reg_empty, vec_full, vec_empty;
   logic            reg_push, vec_push;

   logic            rf_en_d, rf_en_q;
   logic [4:0]      rf_addr_d, rf_addr_q;
   logic [XLEN-1:0] rf_data_d, rf_data_q;
   logic            vf_en_d, vf_en_q;
   logic [4:0]      vf_addr_d, vf_addr_q;
   logic [VW-1:0]   vf_data_d, vf_data_q;
   logic [2:0]      err_d, err_q;
   logic            reg_unf, reg_col, reg_ovf;
   logic            vec_unf, vec_col, vec_ovf;

   assign vec_head_unused = '0;
   assign reg_push = buffer_register & v_reg_wr_en;
   assign vec_push = buffer_vector & v_vec_wr_en;

   wb_buffer #(.WIDTH(XLEN + 5), .DEPTH(BUF_DEPTH)) u_reg_buf (
      .clk   (clk),
      .rst   (rst),
      .push  (reg_push),
      .pop   (buffer_register_sel),
      .din   ({v_wr_reg, v_reg_data}),
      .dout  (reg_head),
      .count (reg_buf_count),
      .full  (reg_full),
      .empty (reg_empty)
   );

   wb_buffer #(.WIDTH(VW + 5), .DEPTH(BUF_DEPTH)) u_vec_buf (
      .clk   (clk),
      .rst   (rst),
      .push  (vec_push),
      .pop   (buffer_vector_sel),
      .din   ({v_wr_reg, v_vec_data}),
      .dout  (vec_head),
      .count (vec_buf_count),
      .full  (vec_full),
      .empty (vec_empty)
   );

   // Register-file port source: drain, then direct vector pipe, then scalar.
   always_comb begin
      rf_en_d   = 1'b0;
      rf_addr_d = s_wr_reg;
      rf_data_d = s_reg_data;
      reg_unf   = 1'b0;
      if (buffer_register_sel) begin
         rf_en_d   = ~reg_empty;
         rf_addr_d = reg_head[XLEN+4:XLEN];
         rf_data_d = reg_head[XLEN-1:0];
         reg_unf   = reg_empty;
      end else if (register_wb_sel & v_reg_wr_en) begin
         rf_en_d   = 1'b1;
         rf_addr_d = v_wr_reg;
         rf_data_d = v_reg_data;
      end else if (s_reg_wr_en) begin
         rf_en_d   = 1'b1;
      end
      reg_col = s_reg_wr_en & (buffer_register_sel | (register_wb_sel & v_reg_wr_en));
      // A same-cycle drain frees the slot, so a full FIFO only overflows without one.
      reg_ovf = reg_push & reg_full & ~buffer_register_sel;
   end

   // Vector-file port source, same priority as the register path.
   always_comb begin
      vf_en_d   = 1'b0;
      vf_addr_d = s_wr_reg;
      vf_data_d = s_vec_data;
      vec_unf   = 1'b0;
      if (buffer_vector_sel) begin
         vf_en_d   = ~vec_empty;
         vf_addr_d = vec_head[VW+4:VW];
         vf_data_d = vec_head[VW-1:0];
         vec_unf   = vec_empty;
      end else if (vector_wb_sel & v_vec_wr_en) begin
         vf_en_d   = 1'b1;
         vf_addr_d = v_wr_reg;
         vf_data_d = v_vec_data;
      end else if (s_vec_wr_en) begin
         vf_en_d   = 1'b1;
      end
      vec_col = s_vec_wr_en & (buffer_vector_sel | (vector_wb_sel & v_vec_wr_en));
      vec_ovf = vec_push & vec_full & ~buffer_vector_sel;
   end

   // Sticky error accumulation.
   always_comb begin
      err_d          = err_q;
      err_d[ERR_OVF] = err_q[ERR_OVF] | reg_ovf | vec_ovf;
      err_d[ERR_UNF] = err_q[ERR_UNF] | reg_unf | vec_unf;
      err_d[ERR_COL] = err_q[ERR_COL] | reg_col | vec_col;
   end

   // Registered write ports and error flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_en_q   <= 1'b0;
         rf_addr_q <= '0;
         rf_data_q <= '0;
         vf_en_q   <= 1'b0;
         vf_addr_q <= '0;
         vf_data_q <= '0;
         err_q     <= '0;
      end else begin
         rf_en_q   <= rf_en_d;
         rf_addr_q <= rf_addr_d;
         rf_data_q <= rf_data_d;
         vf_en_q   <= vf_en_d;
         vf_addr_q <= vf_addr_d;
         vf_data_q <= vf_data_d;
         err_q     <= err_d;
      end
   end

   assign rf_wr_en   = rf_en_q;
   assign rf_wr_addr = rf_addr_q;
   assign rf_wr_data = rf_data_q;
   assign vf_wr_en   = vf_en_q;
   assign vf_wr_addr = vf_addr_q;
   assign vf_wr_data = vf_data_q;
   assign err        = err_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios followed by random traffic,
// all checked against a queue-based reference model of the writeback rules.
module tb_writeback_arbiter;

   localparam int XLEN  = 32;
   localparam int VL    = 4;
   localparam int VW    = XLEN * VL;
   localparam int DEPTH = 2;
   localparam int CW    = $clog2(DEPTH + 1);

   logic            clk = 1'b0;
   logic            rst;
   logic            s_reg_wr_en, s_vec_wr_en, v_reg_wr_en, v_vec_wr_en;
   logic [4:0]      s_wr_reg, v_wr_reg;
   logic [XLEN-1:0] s_reg_data, v_reg_data;
   logic [VW-1:0]   s_vec_data, v_vec_data;
   logic            register_wb_sel, vector_wb_sel;
   logic            buffer_register, buffer_vector;
   logic            buffer_register_sel, buffer_vector_sel;
   logic            rf_wr_en, vf_wr_en;
   logic [4:0]      rf_wr_addr, vf_wr_addr;
   logic [XLEN-1:0] rf_wr_data;
   logic [VW-1:0]   vf_wr_data;
   logic [CW-1:0]   reg_buf_count, vec_buf_count;
   logic [2:0]      err;

   int checks = 0;
   int errors = 0;

   // Reference model state: one queue per path holding {addr, data}.
   logic [VW+4:0] q [2][$];
   logic          e_en   [2];
   logic [4:0]    e_addr [2];
   logic [VW-1:0] e_data [2];
   logic [2:0]    e_err;
   logic          e_rst;

   writeback_arbiter #(.XLEN(XLEN), .VLANES(VL), .BUF_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .s_reg_wr_en(s_reg_wr_en), .s_vec_wr_en(s_vec_wr_en),
      .s_wr_reg(s_wr_reg), .s_reg_data(s_reg_data), .s_vec_data(s_vec_data),
      .v_reg_wr_en(v_reg_wr_en), .v_vec_wr_en(v_vec_wr_en),
      .v_wr_reg(v_wr_reg), .v_reg_data(v_reg_data), .v_vec_data(v_vec_data),
      .register_wb_sel(register_wb_sel), .vector_wb_sel(vector_wb_sel),
      .buffer_register(buffer_register), .buffer_vector(buffer_vector),
      .buffer_register_sel(buffer_register_sel), .buffer_vector_sel(buffer_vector_sel),
      .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
      .vf_wr_en(vf_wr_en), .vf_wr_addr(vf_wr_addr), .vf_wr_data(vf_wr_data),
      .reg_buf_count(reg_buf_count), .vec_buf_count(vec_buf_count), .err(err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic idle_inputs();
      rst = 1'b0;
      s_reg_wr_en = 0; s_vec_wr_en = 0; v_reg_wr_en = 0; v_vec_wr_en = 0;
      s_wr_reg = 0; v_wr_reg = 0;
      s_reg_data = 0; v_reg_data = 0; s_vec_data = 0; v_vec_data = 0;
      register_wb_sel = 0; vector_wb_sel = 0;
      buffer_register = 0; buffer_vector = 0;
      buffer_register_sel = 0; buffer_vector_sel = 0;
   endtask

   // One path of the writeback rules, evaluated on the model's queues.
   task automatic model_path(input int p, input logic drain, wbs, bufc, ven, sen,
                             input logic [VW-1:0] vd, sd);
      int n;
      logic [VW+4:0] head;
      n = q[p].size();
      e_en[p] = 1'b0;
      if (drain) begin
         if (n == 0) e_err[1] = 1'b1;
         else begin
            head = q[p].pop_front();
            e_en[p] = 1'b1; e_addr[p] = head[VW+4:VW]; e_data[p] = head[VW-1:0];
         end
      end else if (wbs && ven) begin
         e_en[p] = 1'b1; e_addr[p] = v_wr_reg; e_data[p] = vd;
      end else if (sen) begin
         e_en[p] = 1'b1; e_addr[p] = s_wr_reg; e_data[p] = sd;
      end
      if (sen && (drain || (wbs && ven))) e_err[2] = 1'b1;
      if (bufc && ven) begin
         if (n == DEPTH && !drain) e_err[0] = 1'b1;
         else q[p].push_back({v_wr_reg, vd});
      end
   endtask

   task automatic model_step();
      e_rst = rst;
      if (rst) begin
         q[0].delete(); q[1].delete();
         for (int p = 0; p < 2; p++) begin
            e_en[p] = 1'b0; e_addr[p] = '0; e_data[p] = '0;
         end
         e_err = '0;
      end else begin
         model_path(0, buffer_register_sel, register_wb_sel, buffer_register,
                    v_reg_wr_en, s_reg_wr_en, VW'(v_reg_data), VW'(s_reg_data));
         model_path(1, buffer_vector_sel, vector_wb_sel, buffer_vector,
                    v_vec_wr_en, s_vec_wr_en, v_vec_data, s_vec_data);
      end
   endtask

   // Apply the current inputs for one clock and compare every output.
   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      chk("rf_wr_en", VW'(rf_wr_en), VW'(e_en[0]));
      if (e_en[0] || e_rst) begin
         chk("rf_wr_addr", VW'(rf_wr_addr), VW'(e_addr[0]));
         chk("rf_wr_data", VW'(rf_wr_data), e_data[0]);
      end
      chk("vf_wr_en", VW'(vf_wr_en), VW'(e_en[1]));
      if (e_en[1] || e_rst) begin
         chk("vf_wr_addr", VW'(vf_wr_addr), VW'(e_addr[1]));
         chk("vf_wr_data", vf_wr_data, e_data[1]);
      end
      chk("reg_buf_count", VW'(reg_buf_count), VW'(q[0].size()));
      chk("vec_buf_count", VW'(vec_buf_count), VW'(q[1].size()));
      chk("err", VW'(err), VW'(e_err));
   endtask

   task automatic do_reset();
      idle_inputs(); rst = 1'b1; cycle(); rst = 1'b0;
   endtask

   function automatic logic [VW-1:0] rvec();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   logic [VW-1:0] d0, d1, d2;

   initial begin
      idle_inputs();
      rst = 1'b1;
      cycle(); cycle();
      chk("reset_rf_en",  VW'(rf_wr_en), '0);
      chk("reset_vf_en",  VW'(vf_wr_en), '0);
      chk("reset_counts", VW'({reg_buf_count, vec_buf_count}), '0);
      chk("reset_err",    VW'(err), '0);
      idle_inputs();

      // Direct scalar write.
      s_reg_wr_en = 1; s_wr_reg = 5; s_reg_data = 32'hA5A5;
      cycle();
      chk("scalar_en",   VW'(rf_wr_en), VW'(1));
      chk("scalar_addr", VW'(rf_wr_addr), VW'(5));
      chk("scalar_data", VW'(rf_wr_data), VW'(32'hA5A5));
      chk("scalar_vf",   VW'(vf_wr_en), VW'(0));

      // Displace then drain.
      idle_inputs();
      s_reg_wr_en = 1; s_wr_reg = 3; s_reg_data = 32'h11;
      v_reg_wr_en = 1; v_wr_reg = 3; v_reg_data = 32'h22; buffer_register = 1;
      cycle();
      chk("disp_data1", VW'(rf_wr_data), VW'(32'h11));
      chk("disp_cnt1",  VW'(reg_buf_count), VW'(1));
      idle_inputs(); buffer_register_sel = 1;
      cycle();
      chk("disp_en2",   VW'(rf_wr_en), VW'(1));
      chk("disp_data2", VW'(rf_wr_data), VW'(32'h22));
      chk("disp_cnt2",  VW'(reg_buf_count), VW'(0));
      chk("disp_err",   VW'(err), VW'(0));

      // Vector direct with a colliding scalar vector write.
      idle_inputs();
      v_vec_wr_en = 1; vector_wb_sel = 1; v_wr_reg = 7; v_vec_data = rvec();
      s_vec_wr_en = 1; s_vec_data = rvec();
      d0 = v_vec_data;
      cycle();
      chk("vdir_addr", VW'(vf_wr_addr), VW'(7));
      chk("vdir_data", vf_wr_data, d0);
      chk("vdir_col",  VW'(err[2]), VW'(1));
      do_reset();

      // Overflow: three captures into a two-deep FIFO, then two drains.
      d0 = rvec(); d1 = rvec(); d2 = rvec();
      idle_inputs(); v_vec_wr_en = 1; buffer_vector = 1;
      v_wr_reg = 1; v_vec_data = d0; cycle();
      v_wr_reg = 2; v_vec_data = d1; cycle();
      v_wr_reg = 3; v_vec_data = d2; cycle();
      chk("ovf_count", VW'(vec_buf_count), VW'(2));
      chk("ovf_err",   VW'(err[0]), VW'(1));
      idle_inputs(); buffer_vector_sel = 1;
      cycle();
      chk("ovf_drain1", vf_wr_data, d0);
      cycle();
      chk("ovf_drain2", vf_wr_data, d1);
      do_reset();

      // Underflow, sticky across idle cycles.
      idle_inputs(); buffer_register_sel = 1;
      cycle();
      chk("unf_en",  VW'(rf_wr_en), VW'(0));
      idle_inputs();
      cycle(); cycle();
      chk("unf_sticky", VW'(err), VW'(3'b010));

      // Reset mid-flight with two buffered entries.
      do_reset();
      idle_inputs(); v_reg_wr_en = 1; buffer_register = 1; v_reg_data = 32'h77;
      cycle(); cycle();
      idle_inputs(); rst = 1'b1; cycle();
      chk("mrst_count", VW'(reg_buf_count), VW'(0));
      chk("mrst_err",   VW'(err), VW'(0));
      chk("mrst_en",    VW'({rf_wr_en, vf_wr_en}), VW'(0));
      idle_inputs(); buffer_register_sel = 1; cycle();
      chk("mrst_unf", VW'(err[1]), VW'(1));

      // Random traffic.
      for (int i = 0; i < 1500; i++) begin
         rst                 = ($urandom_range(0, 79) == 0);
         s_reg_wr_en         = $urandom_range(0, 1);
         s_vec_wr_en         = $urandom_range(0, 1);
         v_reg_wr_en         = $urandom_range(0, 1);
         v_vec_wr_en         = $urandom_range(0, 1);
         s_wr_reg            = 5'($urandom);
         v_wr_reg            = 5'($urandom);
         s_reg_data          = $urandom;
         v_reg_data          = $urandom;
         s_vec_data          = rvec();
         v_vec_data          = rvec();
         register_wb_sel     = ($urandom_range(0, 3) == 0);
         vector_wb_sel       = ($urandom_range(0, 3) == 0);
         buffer_register     = $urandom_range(0, 1);
         buffer_vector       = $urandom_range(0, 1);
         buffer_register_sel = ($urandom_range(0, 2) == 0);
         buffer_vector_sel   = ($urandom_range(0, 2) == 0);
         cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
